// File: rtl/reg_file_gen_if.sv
// Bus bundle for reg_file_gen: scalar ports, bitmap parallel port and
// streamed bitmap load handshake.
interface reg_file_gen_if #(
    parameter int N_WIDTH = 16,
    parameter int N_DEPTH = 16,
    parameter int B_WIDTH = 1536,
    parameter int B_DEPTH = 3,
    parameter int CHUNK   = 64
);
    localparam int AW  = $clog2(N_DEPTH);
    localparam int BAW = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;

    logic [AW-1:0]      rd_addr_1;
    logic [N_WIDTH-1:0] rd_data_1;
    logic [AW-1:0]      rd_addr_2;
    logic [N_WIDTH-1:0] rd_data_2;
    logic               wr;
    logic [AW-1:0]      wr_addr;
    logic [N_WIDTH-1:0] wr_data;
    logic [BAW-1:0]     rbm_addr;
    logic [B_WIDTH-1:0] rbm_data;
    logic               wbm;
    logic [BAW-1:0]     wbm_addr;
    logic [B_WIDTH-1:0] wbm_data;
    logic               ld_start;
    logic [BAW-1:0]     ld_addr;
    logic               ld_abort;
    logic               ld_valid;
    logic [CHUNK-1:0]   ld_data;
    logic               ld_ready;
    logic               ld_busy;
    logic               ld_done;

    modport master (
        output rd_addr_1, rd_addr_2, wr, wr_addr, wr_data, rbm_addr,
               wbm, wbm_addr, wbm_data, ld_start, ld_addr, ld_abort,
               ld_valid, ld_data,
        input  rd_data_1, rd_data_2, rbm_data, ld_ready, ld_busy, ld_done
    );

    modport slave (
        input  rd_addr_1, rd_addr_2, wr, wr_addr, wr_data, rbm_addr,
               wbm, wbm_addr, wbm_data, ld_start, ld_addr, ld_abort,
               ld_valid, ld_data,
        output rd_data_1, rd_data_2, rbm_data, ld_ready, ld_busy, ld_done
    );
endinterface

// File: rtl/reg_file_gen.sv
// Scalar register file (2R/1W, optional bypass) plus wide bitmap registers
// loaded in parallel or streamed CHUNK-wide beats by a small sequencer.
module reg_file_gen #(
    parameter int N_WIDTH = 16,
    parameter int N_DEPTH = 16,
    parameter int B_WIDTH = 1536,
    parameter int B_DEPTH = 3,
    parameter int CHUNK   = 64,
    parameter int BYPASS  = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_gen_if.slave bus
);
    localparam int BAW   = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
    localparam int BEATS = B_WIDTH / CHUNK;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BAW:0]   BDEP      = B_DEPTH[BAW:0];
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;

    logic [N_DEPTH-1:0][N_WIDTH-1:0] sreg;
    logic [B_WIDTH-1:0]              breg [B_DEPTH];
    ld_state_t                       state, state_nx;
    logic [BCW-1:0]                  beat, beat_nx;
    logic [BAW-1:0]                  tgt, tgt_nx;
    logic                            beat_acc;

    function automatic logic bm_ok(input logic [BAW-1:0] a);
        return {1'b0, a} < BDEP;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sreg <= '0;
        else if (bus.wr) sreg[bus.wr_addr] <= bus.wr_data;
    end

    always_comb begin
        bus.rd_data_1 = sreg[bus.rd_addr_1];
        bus.rd_data_2 = sreg[bus.rd_addr_2];
        if (BYPASS != 0 && bus.wr && bus.wr_addr == bus.rd_addr_1) bus.rd_data_1 = bus.wr_data;
        if (BYPASS != 0 && bus.wr && bus.wr_addr == bus.rd_addr_2) bus.rd_data_2 = bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            tgt   <= '0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
            tgt   <= tgt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        beat_nx      = beat;
        tgt_nx       = tgt;
        beat_acc     = 1'b0;
        bus.ld_busy  = 1'b0;
        bus.ld_ready = 1'b0;
        bus.ld_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ld_start && bm_ok(bus.ld_addr)) begin
                    state_nx = LOAD;
                    tgt_nx   = bus.ld_addr;
                    beat_nx  = '0;
                end
            end
            LOAD: begin
                bus.ld_busy  = 1'b1;
                bus.ld_ready = 1'b1;
                // abort wins over a beat presented in the same cycle
                if (bus.ld_abort) begin
                    state_nx = IDLE;
                end else if (bus.ld_valid) begin
                    beat_acc = 1'b1;
                    beat_nx  = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_nx = DONE;
                        beat_nx  = '0;
                    end
                end
            end
            DONE: begin
                bus.ld_busy = 1'b1;
                bus.ld_done = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    for (genvar b = 0; b < B_DEPTH; b++) begin : g_breg
        logic hit_wbm, hit_ld;
        // parallel writes to the register under streamed load are dropped
        assign hit_wbm = bus.wbm && bus.wbm_addr == BAW'(b) &&
                         !(bus.ld_busy && tgt == BAW'(b));
        assign hit_ld  = beat_acc && tgt == BAW'(b);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                breg[b] <= '0;
            end else begin
                if (hit_wbm) breg[b] <= bus.wbm_data;
                if (hit_ld)  breg[b][beat*CHUNK +: CHUNK] <= bus.ld_data;
            end
        end
    end

    always_comb begin
        bus.rbm_data = '0;
        for (int b = 0; b < B_DEPTH; b++)
            if (bus.rbm_addr == BAW'(b)) bus.rbm_data = breg[b];
    end
endmodule
